// File: rtl/irs_event_controller_v4.sv
// irs_event_controller_v4: trigger admission, per-block history/lock handshakes and a block-info FIFO.
module irs_event_controller_v4 #(
  parameter int NUM_L4     = 4,
  parameter int MAX_BLOCKS = 8,
  parameter int FIFO_LOG2  = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [15:0]          pps_counter_i,
  input  logic [31:0]          cycle_counter_i,
  input  logic                 trig_i,
  input  logic [8:0]           trig_offset_i,
  input  logic [3:0]           trig_nblocks_i,
  input  logic [NUM_L4-1:0]    trig_l4_i,
  input  logic [NUM_L4-1:0]    trig_l4_new_i,
  input  logic                 irs_wrstrb_i,
  output logic [8:0]           hist_offset_o,
  output logic                 hist_req_o,
  input  logic [8:0]           hist_block_i,
  input  logic                 hist_ack_i,
  output logic [8:0]           lock_block_o,
  output logic                 lock_req_o,
  output logic [71:0]          irs_buff_dat_o,
  output logic                 irs_buff_empty_o,
  input  logic                 irs_buff_read_i,
  input  logic [FIFO_LOG2:0]   prog_full_thresh_i,
  output logic                 block_buffer_full_o,
  output logic [FIFO_LOG2:0]   block_buffer_count_o,
  output logic                 busy_o,
  output logic [15:0]          event_count_o,
  output logic [15:0]          trig_dropped_o
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state, state_nx;
  logic trig_q, rise, accept, wr, rd, last;
  logic [NUM_L4-1:0] sh_l4, sh_l4n, ev_l4, ev_l4n;
  logic [3:0] n_cl, n_q, k_q;
  logic [8:0] off_q;
  logic [15:0] pps_q;
  logic [31:0] cyc_q;
  logic [71:0] word;
  logic [71:0] mem [DEPTH];
  logic [FIFO_LOG2-1:0] wp, rp;
  logic [FIFO_LOG2:0] cnt_nx;
  assign rise   = trig_i & ~trig_q;
  assign n_cl   = trig_nblocks_i == 4'd0 ? 4'd1 :
                  trig_nblocks_i > 4'(MAX_BLOCKS) ? 4'(MAX_BLOCKS) : trig_nblocks_i;
  // Admission reserves room for every block of the event up front.
  assign accept = rise && state == IDLE && !block_buffer_full_o &&
                  (32'(block_buffer_count_o) + 32'(n_cl) <= 32'(DEPTH));
  assign wr     = state == REQ && hist_ack_i;
  assign rd     = irs_buff_read_i && !irs_buff_empty_o;
  assign last   = k_q == n_q - 4'd1;
  assign cnt_nx = block_buffer_count_o + (FIFO_LOG2+1)'(wr) - (FIFO_LOG2+1)'(rd);
  assign word   = {cyc_q, pps_q, 1'b0, last, 6'(ev_l4n), 6'(ev_l4), k_q == 4'd0, hist_block_i};
  assign irs_buff_empty_o = block_buffer_count_o == '0;
  assign irs_buff_dat_o   = irs_buff_empty_o ? '0 : mem[rp];
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx      = state;
    hist_req_o    = state == REQ;
    busy_o        = state != IDLE;
    hist_offset_o = hist_req_o ? off_q + 9'(n_q) - 9'(k_q) - 9'd1 : 9'd0;
    state_nx      = state == IDLE ? (accept ? REQ : IDLE) :
                    state == GAP  ? REQ :
                    hist_ack_i    ? (last ? IDLE : GAP) : REQ;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      trig_q <= 1'b0;
      sh_l4 <= '0;
      sh_l4n <= '0;
      ev_l4 <= '0;
      ev_l4n <= '0;
      n_q <= '0;
      k_q <= '0;
      off_q <= '0;
      pps_q <= '0;
      cyc_q <= '0;
      event_count_o <= '0;
      trig_dropped_o <= '0;
      lock_req_o <= 1'b0;
      lock_block_o <= '0;
      wp <= '0;
      rp <= '0;
      block_buffer_count_o <= '0;
      block_buffer_full_o <= 1'b0;
    end else begin
      trig_q <= trig_i;
      if (irs_wrstrb_i) begin
        sh_l4  <= trig_l4_i;
        sh_l4n <= trig_l4_new_i;
      end
      if (accept) begin
        n_q <= n_cl;
        k_q <= '0;
        off_q <= trig_offset_i;
        pps_q <= pps_counter_i;
        cyc_q <= cycle_counter_i;
        ev_l4 <= sh_l4;
        ev_l4n <= sh_l4n;
        event_count_o <= event_count_o + 16'd1;
      end else if (rise && trig_dropped_o != 16'hFFFF)
        trig_dropped_o <= trig_dropped_o + 16'd1;
      if (wr) k_q <= k_q + 4'd1;
      lock_req_o <= wr;
      if (wr) lock_block_o <= hist_block_i;
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      block_buffer_count_o <= cnt_nx;
      block_buffer_full_o <= cnt_nx >= prog_full_thresh_i;
    end
  always_ff @(posedge clk_i)
    if (wr) mem[wp] <= word;
endmodule

// File: tb/tb_irs_event_controller_v4.sv
// tb_irs_event_controller_v4: randomized scoreboard bench with an event-level reference model.
module tb_irs_event_controller_v4;
  localparam int NL4 = 4, MAXB = 8, FL2 = 4, DEPTH = 16;
  logic clk_i = 1'b0, rst_n_i = 1'b0;
  logic [15:0] pps_counter_i = '0;
  logic [31:0] cycle_counter_i = '0;
  logic trig_i = 1'b0, irs_wrstrb_i = 1'b0, hist_ack_i = 1'b0, irs_buff_read_i = 1'b0;
  logic [8:0] trig_offset_i = '0, hist_block_i = '0;
  logic [3:0] trig_nblocks_i = '0;
  logic [NL4-1:0] trig_l4_i = '0, trig_l4_new_i = '0;
  logic [FL2:0] prog_full_thresh_i = 5'd16;
  logic [8:0] hist_offset_o, lock_block_o;
  logic hist_req_o, lock_req_o, irs_buff_empty_o, block_buffer_full_o, busy_o;
  logic [71:0] irs_buff_dat_o;
  logic [FL2:0] block_buffer_count_o;
  logic [15:0] event_count_o, trig_dropped_o;

  irs_event_controller_v4 #(.NUM_L4(NL4), .MAX_BLOCKS(MAXB), .FIFO_LOG2(FL2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .pps_counter_i(pps_counter_i),
    .cycle_counter_i(cycle_counter_i), .trig_i(trig_i), .trig_offset_i(trig_offset_i),
    .trig_nblocks_i(trig_nblocks_i), .trig_l4_i(trig_l4_i), .trig_l4_new_i(trig_l4_new_i),
    .irs_wrstrb_i(irs_wrstrb_i), .hist_offset_o(hist_offset_o), .hist_req_o(hist_req_o),
    .hist_block_i(hist_block_i), .hist_ack_i(hist_ack_i), .lock_block_o(lock_block_o),
    .lock_req_o(lock_req_o), .irs_buff_dat_o(irs_buff_dat_o), .irs_buff_empty_o(irs_buff_empty_o),
    .irs_buff_read_i(irs_buff_read_i), .prog_full_thresh_i(prog_full_thresh_i),
    .block_buffer_full_o(block_buffer_full_o), .block_buffer_count_o(block_buffer_count_o),
    .busy_o(busy_o), .event_count_o(event_count_o), .trig_dropped_o(trig_dropped_o));

  always #5 clk_i = ~clk_i;

  logic [8:0] blk_tab [512];
  int n_chk = 0, n_fail = 0;
  bit hold = 1'b0;
  int pop_budget = 0, wr_n = 0, rd_n = 0, remaining = 0;
  logic [15:0] m_ev = '0, m_drop = '0;
  logic [NL4-1:0] sh_l4 = '0, sh_l4n = '0;
  logic [71:0] exp_words[$];
  logic [8:0] exp_offs[$], exp_locks[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // history buffer model: acks after a random delay, block looked up from a fixed random table
  initial begin
    int dly = 0;
    bit real_ack = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hist_ack_i) begin
        hist_ack_i = 1'b0;
        if (real_ack) chk("hist_req drop after ack", 72'(hist_req_o), 72'(0));
      end else if (!hold && rst_n_i) begin
        if (hist_req_o) begin
          if (dly == 0) begin
            hist_ack_i = 1'b1;
            hist_block_i = blk_tab[hist_offset_o];
            real_ack = 1'b1;
            wr_n++;
            remaining--;
            dly = $urandom_range(0, 3);
          end else dly--;
        end else if ($urandom_range(0, 9) == 0) begin
          hist_ack_i = 1'b1;
          hist_block_i = 9'($urandom);
          real_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    bit prev_req = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hist_req_o && !prev_req) begin
        if (exp_offs.size() == 0) chk("hist_req unexpected", 72'(1), 72'(0));
        else chk("hist_offset", 72'(hist_offset_o), 72'(exp_offs.pop_front()));
      end
      prev_req = hist_req_o;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (lock_req_o) begin
      if (exp_locks.size() == 0) chk("lock_req unexpected", 72'(1), 72'(0));
      else chk("lock_block", 72'(lock_block_o), 72'(exp_locks.pop_front()));
    end
  end

  // readout: pops randomly within a budget and occasionally reads an empty FIFO
  initial forever begin
    @(negedge clk_i);
    irs_buff_read_i = 1'b0;
    if (!hold && rst_n_i) begin
      if (!irs_buff_empty_o && pop_budget > 0 && $urandom_range(0, 1) == 1) begin
        if (exp_words.size() == 0) chk("fifo word unexpected", 72'(1), 72'(0));
        else chk("fifo word", irs_buff_dat_o, exp_words.pop_front());
        irs_buff_read_i = 1'b1;
        rd_n++;
        pop_budget--;
      end else if (irs_buff_empty_o && $urandom_range(0, 3) == 0) irs_buff_read_i = 1'b1;
    end
  end

  task automatic trig(input int off, input int nb, input bit strobe);
    int n, cnt;
    bit acc, was_busy;
    hold = 1'b1;
    @(negedge clk_i);
    if (strobe) begin
      trig_l4_i = NL4'($urandom);
      trig_l4_new_i = NL4'($urandom);
      irs_wrstrb_i = 1'b1;
      sh_l4 = trig_l4_i;
      sh_l4n = trig_l4_new_i;
    end
    @(negedge clk_i);
    irs_wrstrb_i = 1'b0;
    trig_l4_i = NL4'($urandom);
    trig_l4_new_i = NL4'($urandom);
    cnt = wr_n - rd_n;
    chk("count", 72'(block_buffer_count_o), 72'(cnt));
    chk("empty", 72'(irs_buff_empty_o), 72'(cnt == 0));
    chk("full", 72'(block_buffer_full_o), 72'(cnt >= int'(prog_full_thresh_i)));
    cycle_counter_i = $urandom;
    pps_counter_i = 16'($urandom);
    trig_offset_i = 9'(off);
    trig_nblocks_i = 4'(nb);
    trig_i = 1'b1;
    n = nb == 0 ? 1 : (nb > MAXB ? MAXB : nb);
    was_busy = remaining > 0;
    acc = !was_busy && (DEPTH - cnt) >= n && cnt < int'(prog_full_thresh_i);
    if (acc) begin
      m_ev++;
      remaining = n;
      for (int k = 0; k < n; k++) begin
        logic [8:0] o;
        o = 9'((off + n - 1 - k) % 512);
        exp_offs.push_back(o);
        exp_locks.push_back(blk_tab[o]);
        exp_words.push_back({cycle_counter_i, pps_counter_i, 1'b0, k == n - 1,
                             2'b00, sh_l4n, 2'b00, sh_l4, k == 0, blk_tab[o]});
      end
    end else if (m_drop != 16'hFFFF) m_drop++;
    @(negedge clk_i);
    trig_i = 1'b0;
    hold = 1'b0;
    chk("event_count", 72'(event_count_o), 72'(m_ev));
    chk("trig_dropped", 72'(trig_dropped_o), 72'(m_drop));
    chk("busy", 72'(busy_o), 72'(acc || was_busy));
    if (!was_busy) chk("first req", 72'(hist_req_o), 72'(acc));
  endtask

  task automatic wait_idle();
    int g = 0;
    while (remaining > 0 && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    if (remaining > 0) chk("idle timeout", 72'(remaining), 72'(0));
    repeat (2) @(negedge clk_i);
  endtask

  task automatic drain();
    int g = 0;
    pop_budget = 1000;
    while ((wr_n != rd_n || remaining > 0) && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    if (wr_n != rd_n) chk("drain timeout", 72'(wr_n - rd_n), 72'(0));
    pop_budget = 0;
    @(negedge clk_i);
  endtask

  task automatic reset_mid();
    int base, g = 0;
    base = wr_n;
    trig(11, 4, 1'b1);
    while (wr_n - base < 2 && g < 200) begin
      @(negedge clk_i);
      g++;
    end
    hold = 1'b1;
    #2;
    rst_n_i = 1'b0;
    hist_ack_i = 1'b0;
    #1;
    chk("rst empty", 72'(irs_buff_empty_o), 72'(1));
    chk("rst count", 72'(block_buffer_count_o), 72'(0));
    chk("rst hist_req", 72'(hist_req_o), 72'(0));
    chk("rst busy", 72'(busy_o), 72'(0));
    chk("rst event_count", 72'(event_count_o), 72'(0));
    chk("rst dropped", 72'(trig_dropped_o), 72'(0));
    chk("rst lock_req", 72'(lock_req_o), 72'(0));
    exp_words.delete();
    exp_offs.delete();
    exp_locks.delete();
    wr_n = 0;
    rd_n = 0;
    remaining = 0;
    m_ev = '0;
    m_drop = '0;
    sh_l4 = '0;
    sh_l4n = '0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    hold = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) blk_tab[i] = 9'($urandom);
    blk_tab[5] = 9'h1A3;
    repeat (2) @(negedge clk_i);
    chk("reset empty", 72'(irs_buff_empty_o), 72'(1));
    chk("reset count", 72'(block_buffer_count_o), 72'(0));
    chk("reset outputs", 72'({hist_req_o, lock_req_o, busy_o, block_buffer_full_o, hist_offset_o, lock_block_o}), 72'(0));
    chk("reset counters", 72'({event_count_o, trig_dropped_o}), 72'(0));
    chk("reset dat", irs_buff_dat_o, 72'(0));
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
    pop_budget = 1000;
    trig(5, 1, 1'b1);   wait_idle();
    trig(3, 4, 1'b1);   wait_idle();
    trig(7, 0, 1'b0);   wait_idle();
    trig(100, 15, 1'b1); wait_idle();
    trig(510, 4, 1'b1); wait_idle();
    trig(20, 4, 1'b1);
    trig(30, 2, 1'b0);  wait_idle();
    drain();
    trig(40, 8, 1'b1);  wait_idle();
    trig(50, 6, 1'b0);  wait_idle();
    trig(60, 3, 1'b0);
    prog_full_thresh_i = 5'd12;
    trig(61, 1, 1'b0);
    prog_full_thresh_i = 5'd16;
    pop_budget = 1;
    for (int g = 0; g < 100 && pop_budget > 0; g++) @(negedge clk_i);
    trig(70, 3, 1'b1); wait_idle();
    trig(71, 1, 1'b0);
    drain();
    reset_mid();
    trig(9, 2, 1'b1);   wait_idle();
    drain();
    for (int i = 0; i < 40; i++) begin
      pop_budget += $urandom_range(0, 6);
      trig(int'($urandom_range(0, 511)), int'($urandom_range(0, 15)), 1'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk_i);
    end
    wait_idle();
    drain();
    chk("words left", 72'(exp_words.size()), 72'(0));
    chk("offsets left", 72'(exp_offs.size()), 72'(0));
    chk("locks left", 72'(exp_locks.size()), 72'(0));
    chk("final empty", 72'(irs_buff_empty_o), 72'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
